// File: rtl/nn_mul_share_arb.sv
// nn_mul_share_arb: round-robin share of one unsigned A_W x B_W multiplier
// among NUM_REQ requesters, with a MUL_STAGES-deep registered pipeline and
// a tagged response bus.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both 1. A producer holds valid and its payload stable
// until it sees ready; ready may be returned combinationally in the same
// cycle valid rises. rsp_valid/rsp_data/rsp_id hold while rsp_valid && !rsp_ready.
module nn_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int A_W        = 11,
    parameter int B_W        = 13,
    parameter int P_W        = 24,
    parameter int MUL_STAGES = 2,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [P_W-1:0]         rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    logic                  adv;
    logic                  found;
    logic                  fire;
    logic [ID_W-1:0]       win;
    logic [ID_W-1:0]       scan;
    logic [ID_W-1:0]       last_grant;
    logic [A_W-1:0]        sel_a;
    logic [B_W-1:0]        sel_b;
    logic [MUL_STAGES-1:0] stg_v;
    logic [ID_W-1:0]       stg_id [MUL_STAGES];
    logic [A_W-1:0]        s1_a;
    logic [B_W-1:0]        s1_b;
    logic [P_W-1:0]        mul_p;

    // The whole pipeline moves only when the output slot is free or draining.
    assign adv       = !rsp_valid || rsp_ready;
    assign rsp_valid = stg_v[MUL_STAGES-1];
    assign rsp_id    = stg_id[MUL_STAGES-1];
    assign busy      = |stg_v;
    assign fire      = found && adv && ap_rst_n;
    assign req_ready = fire ? (NUM_REQ'(1) << win) : '0;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        scan  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_a = req_a[i*A_W +: A_W];
                sel_b = req_b[i*B_W +: B_W];
            end
        end
    end

    // Pointer moves only on an accepted pair; reset gives requester 0 priority.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (fire) begin
            last_grant <= win;
        end
    end

    // Stage-1 operand capture plus valid/id shift register for all stages.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stg_v <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
            for (int k = 0; k < MUL_STAGES; k++) begin
                stg_id[k] <= '0;
            end
        end else if (adv) begin
            stg_v[0] <= fire;
            if (fire) begin
                s1_a      <= sel_a;
                s1_b      <= sel_b;
                stg_id[0] <= win;
            end
            for (int k = 1; k < MUL_STAGES; k++) begin
                stg_v[k]  <= stg_v[k-1];
                stg_id[k] <= stg_id[k-1];
            end
        end
    end

    // Full-width unsigned product of the stage-1 operands.
    assign mul_p = P_W'(s1_a) * P_W'(s1_b);

    generate
        if (MUL_STAGES == 1) begin : g_one_stage
            // Stage 1 is the output stage; its product is taken straight off its operands.
            assign rsp_data = mul_p;
        end else begin : g_multi_stage
            logic [P_W-1:0] pp [1:MUL_STAGES-1];

            // Product enters stage 2 and rides alongside the id to the output.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int k = 1; k < MUL_STAGES; k++) begin
                        pp[k] <= '0;
                    end
                end else if (adv) begin
                    pp[1] <= mul_p;
                    for (int k = 2; k < MUL_STAGES; k++) begin
                        pp[k] <= pp[k-1];
                    end
                end
            end

            assign rsp_data = pp[MUL_STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_nn_mul_share_arb.sv
// Bench for nn_mul_share_arb: directed scenarios plus a random phase, with a
// negedge monitor holding a round-robin reference and an expected-result queue.
module tb_nn_mul_share_arb;

    localparam int NUM_REQ    = 4;
    localparam int A_W        = 11;
    localparam int B_W        = 13;
    localparam int P_W        = 24;
    localparam int MUL_STAGES = 2;
    localparam int ID_W       = 2;
    localparam int E_W        = ID_W + P_W;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '1;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a = '0;
    logic [NUM_REQ*B_W-1:0] req_b = '0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b1;
    logic [P_W-1:0]         rsp_data;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;

    nn_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .A_W(A_W), .B_W(B_W), .P_W(P_W),
        .MUL_STAGES(MUL_STAGES), .ID_W(ID_W)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int                 n_checks = 0;
    int                 n_errors = 0;
    logic [E_W-1:0]     exp_q[$];
    int                 fire_log[$];
    int                 rsp_cyc[$];
    int                 cyc = 0;
    int                 model_lg = NUM_REQ - 1;
    logic [NUM_REQ-1:0] acc = '0;
    logic [NUM_REQ-1:0] exp_rdy;
    logic               hold_pend = 1'b0;
    logic [E_W-1:0]     hold_val;
    logic [E_W-1:0]     got;
    longint unsigned    pa, pb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] model_grant(input logic [NUM_REQ-1:0] v,
                                                       input int lg, input logic can_adv);
        if (!can_adv) return '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (lg + k) % NUM_REQ;
            if (v[j]) return NUM_REQ'(1) << j;
        end
        return '0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_lg  = NUM_REQ - 1;
            exp_q.delete();
            hold_pend = 1'b0;
            acc       = '0;
        end else begin
            if (hold_pend)
                check("rsp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, hold_val});
            exp_rdy = model_grant(req_valid, model_lg, !rsp_valid || rsp_ready);
            check("req_ready", req_ready, exp_rdy);
            if (rsp_valid && rsp_ready) begin
                rsp_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", rsp_valid, 1'b0);
                end else begin
                    got = exp_q.pop_front();
                    check("rsp", {rsp_id, rsp_data}, got);
                end
            end
            hold_pend = rsp_valid && !rsp_ready;
            hold_val  = {rsp_id, rsp_data};
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    pa = longint'(req_a[i*A_W +: A_W]);
                    pb = longint'(req_b[i*B_W +: B_W]);
                    exp_q.push_back({ID_W'(i), P_W'(pa * pb)});
                    fire_log.push_back(i);
                    model_lg = i;
                    acc[i]   = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        req_valid[i]         = v;
        req_a[i*A_W +: A_W]  = a;
        req_b[i*B_W +: B_W]  = b;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_req_ready", req_ready, '0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
        check("drain_empty", exp_q.size(), 0);
        step();
        @(negedge clk);
        check("busy_idle", busy, 1'b0);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int exp_f [8] = '{0, 1, 2, 3, 0, 2, 0, 2};

        // reset values with requests pending
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_busy", busy, 1'b0);
        check("reset_req_ready", req_ready, '0);
        req_valid = '0;
        step();
        rst_n = 1'b1;

        // single request, maximum operands, latency
        set_req(0, 1'b1, 11'd2047, 13'd8191);
        @(negedge clk);
        check("t1_same_cycle_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        for (int k = 1; k < MUL_STAGES; k++) begin
            @(negedge clk);
            check("t1_early_rsp", rsp_valid, 1'b0);
            step();
        end
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_data", rsp_data, 16766977);
        check("t1_rsp_id", rsp_id, 0);
        step();
        @(negedge clk);
        check("t1_busy_after", busy, 1'b0);
        check("t1_valid_after", rsp_valid, 1'b0);
        step();

        // all four streaming, then only 0 and 2
        pulse_reset();
        fire_log.delete();
        rsp_cyc.delete();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, A_W'(i + 1), 13'd100);
        repeat (5) step();
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b0;
        repeat (3) step();
        req_valid = '0;
        drain();
        check("rr_fire_count", fire_log.size(), 8);
        for (int j = 0; j < 8; j++)
            if (j < fire_log.size()) check("rr_fire_order", fire_log[j], exp_f[j]);
        check("rr_rsp_count", rsp_cyc.size(), 8);
        for (int j = 0; j + 1 < rsp_cyc.size(); j++)
            check("rr_rsp_back_to_back", rsp_cyc[j+1] - rsp_cyc[j], 1);

        // stall for three cycles while streaming
        fire_log.delete();
        rsp_cyc.delete();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, A_W'(i + 5), B_W'(i * 7 + 3));
        repeat (4) step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_req_ready", req_ready, '0);
            check("stall_rsp_valid", rsp_valid, 1'b1);
            step();
        end
        rsp_ready = 1'b1;
        repeat (4) step();
        req_valid = '0;
        drain();
        check("stall_no_loss", rsp_cyc.size(), fire_log.size());

        // reset with two entries in flight
        set_req(0, 1'b1, 11'd9, 13'd9);
        set_req(1, 1'b1, 11'd10, 13'd10);
        step();
        step();
        req_valid = '1;
        pulse_reset();
        req_valid = '0;
        repeat (MUL_STAGES + 2) begin
            @(negedge clk);
            check("no_stale_rsp", rsp_valid, 1'b0);
            step();
        end
        req_valid = '1;
        @(negedge clk);
        check("post_rst_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        drain();

        // edge operands: zero and powers of two (pointer now at 0)
        set_req(1, 1'b1, 11'd0, 13'd8191);
        set_req(3, 1'b1, 11'd1024, 13'd4096);
        step();
        step();
        req_valid = '0;
        @(negedge clk);
        check("edge_zero_data", rsp_data, 0);
        check("edge_zero_id", rsp_id, 1);
        step();
        @(negedge clk);
        check("edge_pow2_data", rsp_data, 4194304);
        check("edge_pow2_id", rsp_id, 3);
        step();
        drain();

        // random traffic with random back-pressure
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1'b1, A_W'($urandom_range(0, 2047)), B_W'($urandom_range(0, 8191)));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            acc = '0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the sequence ever wedges.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nn_mul_share_arb.md
Name: nn_mul_share_arb

Overview:
- Round-robin arbiter and pipeline controller that shares one unsigned A_W x B_W multiplier among NUM_REQ requesters, e.g. parallel MAC lanes of one conv/FC layer.
- Accepts one operand pair per cycle and pushes it through a MUL_STAGES-deep registered multiply pipeline.
- Returns each product on a shared response bus, tagged with the requester index.
- Sits between the layer's lane controllers and the multiplier resource, so only one multiplier instance is needed per layer.

Parameters:
NUM_REQ, 4, number of requesters; legal 2..8
A_W, 11, width of operand a (unsigned)
B_W, 13, width of operand b (unsigned)
P_W, 24, product width; must equal A_W+B_W
MUL_STAGES, 2, pipeline depth in registers from accept to response; legal 1..4
ID_W, 2, requester tag width; equals clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock; all state changes on the rising edge
ap_rst_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  bit i: requester i presents an operand pair
req_ready  out  NUM_REQ  bit i: requester i's pair is accepted this cycle; one-hot or zero
req_a  in  NUM_REQ*A_W  packed operand a; slice i belongs to requester i
req_b  in  NUM_REQ*B_W  packed operand b; slice i belongs to requester i
rsp_valid  out  1  rsp_data/rsp_id hold a valid result
rsp_ready  in  1  response consumer accepts the result
rsp_data  out  P_W  unsigned product a*b
rsp_id  out  ID_W  index of the requester that issued the pair
busy  out  1  at least one pipeline stage holds a valid entry

Behaviour:
- Reset, asynchronous while ap_rst_n=0:
  - All stage valid bits cleared. rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req_ready forced to 0 while ap_rst_n=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Reset mid-operation discards all in-flight entries and produces no responses for them. Requesters re-issue.
- Pipeline enable: adv = !rsp_valid || rsp_ready.
  - Whole pipeline shifts one stage when adv=1 and freezes when adv=0.
  - No bubble compaction: a frozen pipeline stays frozen even if inner stages are empty.
- Arbitration, combinational:
  - Candidates are requesters with req_valid=1.
  - Winner is the first candidate found scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 only when adv=1; all other bits are 0.
  - Handshake fires when req_valid[i] && req_ready[i].
- On a fire:
  - Stage-1 captures a, b and id=i with valid=1.
  - last_grant becomes i on that edge.
  - If there is no fire while adv=1, stage-1 captures valid=0.
- last_grant changes only on a fire. Idle cycles and stalls do not move it.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 fires before it is granted.
- Requester rules: a requester must hold req_valid and its operands stable until it sees ready. The block may return ready in the same cycle req_valid rises.
- Arithmetic: product = zero-extended a times zero-extended b, full P_W bits, no truncation or rounding.
  - Product is computed from stage-1 operands and carried through the remaining stages with the id.
- Latency: a pair that fires in cycle t appears with rsp_valid=1 in cycle t+MUL_STAGES, provided adv stayed 1. Each stall cycle adds one cycle.
- Responses come out in fire order.
- rsp_valid, rsp_data and rsp_id are the last-stage registers. They hold stable while rsp_valid && !rsp_ready.
- Throughput: one fire per cycle when rsp_ready=1.
- busy is the OR of all stage valid bits.
- Simultaneous events:
  - A fire and a response handshake in the same cycle are both honoured.
  - If rsp_ready drops in the cycle a request is presented, adv=0, req_ready stays 0 and last_grant does not move.

Test Plan:
- Reset, then only req0 with a=2047, b=8191, rsp_ready=1. Required: req_ready=0001 in the same cycle. rsp_valid=1 with rsp_data=16766977, rsp_id=0 exactly MUL_STAGES cycles later. busy=0 afterwards.
- All four requesters held valid with a=i+1, b=100 and rsp_ready=1. Required: fire order 0,1,2,3,0,1,... one per cycle. Responses 100,200,300,400 with ids 0..3 on consecutive cycles.
- Grant history 0,1,2,3,0, then only req0 and req2 valid. Required: next grant goes to req2, then req0 (pointer stayed at 0), then req2.
- Streaming with rsp_ready held low for 3 cycles. Required: rsp_valid/rsp_data/rsp_id frozen and req_ready=0 during the stall. No response lost or duplicated. Order preserved after release.
- ap_rst_n pulsed low for one cycle with 2 entries in flight. Required: rsp_valid=0 and busy=0 immediately, with no stale response afterwards. First grant after reset goes to requester 0 when all are valid.
- Edge operands a=0, b=8191 and a=1024, b=4096. Required: rsp_data=0 and 4194304 respectively; no sign-extension artefacts.
